// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;
  localparam int DWORD_W = 64;
  localparam int CNT_W   = 4;
endpackage

// File: rtl/dmem_array.sv
// Doubleword store: synchronous write, asynchronous read, one shared address port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DWORD_W-1:0] wdata,
  output logic [DWORD_W-1:0] rdata
);
  logic [DWORD_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];
endmodule

// File: rtl/dmem_responder.sv
// Memory side of the core D-port: one access at a time, LAT cycles of stall,
// ack (and err for out-of-range) pulsed in the completion cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LAT    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req_D,
  input  logic               mem_wen_D,
  input  logic [29:0]        mem_addr_D,
  input  logic [DWORD_W-1:0] mem_wdata_D,
  output logic [DWORD_W-1:0] mem_rdata_D,
  output logic               mem_stall_D,
  output logic               mem_ack_D,
  output logic               mem_err_D
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               wen_q, wen_d;
  logic               oor_q, oor_d;
  logic [DWORD_W-1:0] wdata_q, wdata_d;
  logic [DWORD_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0]  in_idx, arr_addr;
  logic               in_oor, done, arr_we;
  logic [DWORD_W-1:0] arr_rdata;
  logic               unused_dword_half;

  // mem_addr_D[0] is byte-address bit 2: doubleword granularity ignores it.
  assign unused_dword_half = mem_addr_D[0];
  assign in_idx = mem_addr_D[ADDR_W:1];
  assign in_oor = |mem_addr_D[29:ADDR_W+1];
  assign done   = (state_q == BUSY) && (cnt_q == '0);

  // Only IDLE needs the live address (LAT=1 reads load rdata at acceptance).
  assign arr_addr = (state_q == IDLE) ? in_idx : idx_q;
  assign arr_we   = done && wen_q && !oor_q;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wen_d   = wen_q;
    oor_d   = oor_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req_D) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          idx_d   = in_idx;
          wen_d   = mem_wen_D;
          oor_d   = in_oor;
          wdata_d = mem_wdata_D;
          if (CNT_INIT == '0 && !mem_wen_D) rdata_d = in_oor ? '0 : arr_rdata;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1) && !wen_q) rdata_d = oor_q ? '0 : arr_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      oor_q   <= oor_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_rdata_D = rdata_q;
  assign mem_ack_D   = done;
  assign mem_err_D   = done && oor_q;
  assign mem_stall_D = !rst && ((state_q == IDLE) ? mem_req_D : (cnt_q != '0));
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LAT=3 and LAT=1 instances, a transaction-level
// reference model checked every cycle, plus literal expectations per access.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req [2];
  logic        wen [2];
  logic [29:0] addr [2];
  logic [63:0] wd [2];
  logic [63:0] rdata [2];
  logic        stall [2];
  logic        ack [2];
  logic        err [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .mem_req_D(req[0]), .mem_wen_D(wen[0]),
    .mem_addr_D(addr[0]), .mem_wdata_D(wd[0]), .mem_rdata_D(rdata[0]),
    .mem_stall_D(stall[0]), .mem_ack_D(ack[0]), .mem_err_D(err[0]));

  dmem_responder #(.ADDR_W(8), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .mem_req_D(req[1]), .mem_wen_D(wen[1]),
    .mem_addr_D(addr[1]), .mem_wdata_D(wd[1]), .mem_rdata_D(rdata[1]),
    .mem_stall_D(stall[1]), .mem_ack_D(ack[1]), .mem_err_D(err[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int u);
    return (u == 0) ? 3 : 1;
  endfunction

  // Reference model: an access accepted in cycle t completes in cycle t+LAT.
  logic [63:0] mm [int];
  bit          pend [2];
  int          k [2];
  bit          pw [2];
  bit          poor [2];
  int          pidx [2];
  logic [63:0] pwd [2];
  logic [63:0] exp_rd [2];
  bit          rd_known [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        chk($sformatf("u%0d rst stall", u), 64'(stall[u]), 64'd0);
        chk($sformatf("u%0d rst ack", u), 64'(ack[u]), 64'd0);
        chk($sformatf("u%0d rst err", u), 64'(err[u]), 64'd0);
        chk($sformatf("u%0d rst rdata", u), rdata[u], 64'd0);
        pend[u] = 0; exp_rd[u] = '0; rd_known[u] = 1;
      end else if (pend[u]) begin
        k[u]++;
        if (k[u] < lat_of(u)) begin
          chk($sformatf("u%0d busy stall", u), 64'(stall[u]), 64'd1);
          chk($sformatf("u%0d busy ack", u), 64'(ack[u]), 64'd0);
          chk($sformatf("u%0d busy err", u), 64'(err[u]), 64'd0);
          if (rd_known[u]) chk($sformatf("u%0d busy rdata", u), rdata[u], exp_rd[u]);
        end else begin
          if (!pw[u]) begin
            if (poor[u]) begin exp_rd[u] = '0; rd_known[u] = 1; end
            else if (mm.exists(u*1024 + pidx[u])) begin
              exp_rd[u] = mm[u*1024 + pidx[u]]; rd_known[u] = 1;
            end else rd_known[u] = 0;
          end
          chk($sformatf("u%0d done stall", u), 64'(stall[u]), 64'd0);
          chk($sformatf("u%0d done ack", u), 64'(ack[u]), 64'd1);
          chk($sformatf("u%0d done err", u), 64'(err[u]), 64'(poor[u]));
          if (rd_known[u]) chk($sformatf("u%0d done rdata", u), rdata[u], exp_rd[u]);
          if (pw[u] && !poor[u]) mm[u*1024 + pidx[u]] = pwd[u];
          pend[u] = 0;
        end
      end else begin
        chk($sformatf("u%0d idle stall", u), 64'(stall[u]), 64'(req[u]));
        chk($sformatf("u%0d idle ack", u), 64'(ack[u]), 64'd0);
        chk($sformatf("u%0d idle err", u), 64'(err[u]), 64'd0);
        if (rd_known[u]) chk($sformatf("u%0d idle rdata", u), rdata[u], exp_rd[u]);
        if (req[u]) begin
          pend[u] = 1; k[u] = 0; pw[u] = wen[u]; pwd[u] = wd[u];
          pidx[u] = int'((addr[u] >> 1) % 256);
          poor[u] = (addr[u] >> 9) != 0;
        end
      end
    end
  end

  // One access; scr corrupts address/data and drops req once the request is in flight.
  task automatic access(input int u, input bit w, input logic [29:0] a, input logic [63:0] d,
                        input bit scr, output logic [63:0] rd, output logic er, output int nst);
    int  n = 0;
    bit  got = 0;
    nst = 0; rd = '0; er = 1'b0;
    @(posedge clk); #1;
    req[u] = 1'b1; wen[u] = w; addr[u] = a; wd[u] = d;
    while (!got && n < 40) begin
      @(negedge clk); n++;
      if (stall[u]) nst++;
      if (ack[u]) begin got = 1; rd = rdata[u]; er = err[u]; end
      else if (scr && nst >= 2) begin addr[u] = a ^ 30'h6; wd[u] = ~d; req[u] = 1'b0; end
    end
    chk($sformatf("u%0d ack seen", u), 64'(got), 64'd1);
    @(posedge clk); #1;
    req[u] = 1'b0;
  endtask

  logic [63:0] rd;
  logic        er;
  int          nst;

  initial begin
    for (int u = 0; u < 2; u++) begin
      req[u] = 0; wen[u] = 0; addr[u] = '0; wd[u] = '0;
      pend[u] = 0; k[u] = 0; exp_rd[u] = '0; rd_known[u] = 1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // LAT=3 write then read
    access(0, 1, 30'h10, 64'hDEAD_BEEF_0123_4567, 0, rd, er, nst);
    chk("l3 wr stall cycles", 64'(nst), 64'd3);
    chk("l3 wr err", 64'(er), 64'd0);
    access(0, 0, 30'h10, 64'h0, 0, rd, er, nst);
    chk("l3 rd data", rd, 64'hDEAD_BEEF_0123_4567);
    chk("l3 rd stall cycles", 64'(nst), 64'd3);

    // LAT=1 index 0 / 255, bit 2 toggled on reads
    access(1, 1, 30'h000, 64'h1, 0, rd, er, nst);
    chk("l1 wr stall cycles", 64'(nst), 64'd1);
    access(1, 1, 30'h1FE, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, er, nst);
    access(1, 0, 30'h000, 64'h0, 0, rd, er, nst);
    chk("l1 rd idx0", rd, 64'h1);
    chk("l1 rd stall cycles", 64'(nst), 64'd1);
    access(1, 0, 30'h1FE, 64'h0, 0, rd, er, nst);
    chk("l1 rd idx255", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    access(1, 0, 30'h1FF, 64'h0, 0, rd, er, nst);
    chk("l1 rd idx255 bit2", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    access(1, 0, 30'h001, 64'h0, 0, rd, er, nst);
    chk("l1 rd idx0 bit2", rd, 64'h1);

    // Out of range
    access(0, 1, 30'h0000, 64'h0123, 0, rd, er, nst);
    access(0, 0, 30'h2000, 64'h0, 0, rd, er, nst);
    chk("oor rd err", 64'(er), 64'd1);
    chk("oor rd data", rd, 64'h0);
    access(0, 1, 30'h2000, 64'h5555, 0, rd, er, nst);
    chk("oor wr err", 64'(er), 64'd1);
    access(0, 0, 30'h0000, 64'h0, 0, rd, er, nst);
    chk("oor wr no commit", rd, 64'h0123);

    // Reset in the second BUSY cycle of a write
    access(0, 1, 30'h8, 64'h4444, 0, rd, er, nst);
    @(posedge clk); #1;
    req[0] = 1'b1; wen[0] = 1'b1; addr[0] = 30'h8; wd[0] = 64'hAAAA;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    chk("mid rst stall", 64'(stall[0]), 64'd0);
    chk("mid rst ack", 64'(ack[0]), 64'd0);
    chk("mid rst rdata", rdata[0], 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    access(0, 0, 30'h8, 64'h0, 0, rd, er, nst);
    chk("rst drops write", rd, 64'h4444);

    // Inputs changed (and req dropped) while stalled
    access(0, 1, 30'h26, 64'h66, 0, rd, er, nst);
    access(0, 1, 30'h20, 64'h77, 1, rd, er, nst);
    chk("scr wr stall cycles", 64'(nst), 64'd3);
    access(0, 0, 30'h20, 64'h0, 0, rd, er, nst);
    chk("scr latched data", rd, 64'h77);
    access(0, 0, 30'h26, 64'h0, 0, rd, er, nst);
    chk("scr other idx intact", rd, 64'h66);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the core's D-port (mem_wen_D / mem_addr_D / mem_wdata_D / mem_rdata_D).
- Holds an on-chip 64-bit doubleword store.
- Services one request at a time with a programmable access latency.
- Stalls the core through mem_stall_D until the access completes.
- Used in the system top and testbench in place of the ideal zero-latency data memory.

Parameters:
- ADDR_W, 8: index bits; store depth = 2^ADDR_W doublewords.
- LAT, 3: access latency in cycles, legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_req_D  input  1  core request valid; held stable by the core while mem_stall_D=1.
- mem_wen_D  input  1  1=write, 0=read.
- mem_addr_D  input  30  byte address bits [31:2].
- mem_wdata_D  input  64  write data.
- mem_rdata_D  output  64  read data, registered.
- mem_stall_D  output  1  core must hold its request and freeze.
- mem_ack_D  output  1  one-cycle pulse when the access completes.
- mem_err_D  output  1  one-cycle pulse with ack when the address is out of range.

Behaviour:
- Reset values:
  - mem_rdata_D=0, mem_ack_D=0, mem_err_D=0, mem_stall_D=0.
  - state=IDLE, cnt=0.
  - Store contents are not cleared by reset.
- Index = mem_addr_D[ADDR_W+2:3]; bit 2 is ignored (doubleword granularity).
- Out of range: mem_addr_D[31:ADDR_W+3] != 0.
- FSM states: IDLE, BUSY.
- IDLE:
  - mem_stall_D = mem_req_D (combinational).
  - On an edge with mem_req_D=1: latch index, wen, wdata, range flag; cnt <= LAT-1; go to BUSY.
- BUSY with cnt>0:
  - mem_stall_D=1; cnt decrements each edge.
  - Request inputs are ignored (values latched at acceptance are used).
- BUSY with cnt==0 (completion cycle):
  - mem_stall_D=0, mem_ack_D=1, mem_err_D = range flag.
  - At the closing edge: a write commits to the store (skipped if out of range); state goes to IDLE.
- Read data timing:
  - mem_rdata_D is loaded at the edge that enters the completion cycle: store[index], or 0 if out of range.
  - It holds its value until the next read completes.
  - Writes do not change mem_rdata_D.
- Timing summary: stall is high for exactly LAT cycles per request, counting the request cycle. With LAT=1 the request cycle stalls and the next cycle is the completion.
- Back-to-back: a request present in the cycle after completion is accepted in IDLE. Minimum request spacing is LAT+1 cycles.
- Write-then-read to the same index returns the new data; the write has committed before the read is accepted.
- rst asserted mid-access:
  - Immediate return to IDLE; the pending access is dropped.
  - A write that has not reached its closing edge does not commit.
  - All outputs go to their reset values.
- mem_req_D=0 while BUSY: no effect. The access completes and is acked.

Decomposition:
- Shared package (dmem_pkg):
  - state enum {IDLE, BUSY}.
  - DWORD_W=64.
  - Width of the latency counter: 4 bits.
- Sub-module dmem_array: single-port synchronous-write, asynchronous-read store (2^ADDR_W x 64). The FSM, counter and handshake stay in dmem_responder.

Test Plan:
- Reset, then idle with mem_req_D=0 for 5 cycles -> all outputs 0, no ack.
- LAT=3: write addr 30'h10 (index 8), data 64'hDEAD_BEEF_0123_4567 -> stall high 3 cycles, ack in cycle 3 with stall low; then read 30'h10 -> mem_rdata_D=64'hDEAD_BEEF_0123_4567 in its ack cycle.
- LAT=1: alternating write/read to index 0 and 255 with values 64'h1 / 64'hFFFF_FFFF_FFFF_FFFF -> each access acked one cycle after request, data correct; bit 2 toggled on the read address returns the same data.
- Out-of-range read at mem_addr_D=30'h0000_2000 (ADDR_W=8) -> ack with mem_err_D=1, mem_rdata_D=0. Out-of-range write -> err pulse and the store is unchanged (verify by reading index 0).
- Write 64'hAAAA to index 4, then assert rst in the second BUSY cycle -> outputs return to 0 immediately; a subsequent read of index 4 returns its prior value, not 64'hAAAA.
- mem_addr_D/mem_wdata_D changed while stalled -> access uses the values latched at acceptance; the changed values are ignored.
